// File: rtl/eth_sw_pkg.sv
// eth_sw_pkg -- shared constants and types for the eth_sw store-and-forward
// packet buffer.
//   DATA_W   : default data word width
//   DEPTH    : default buffer depth in words (power of two)
//   RUNT_MIN : minimum packet length in words when runt dropping is built in
//   state_t  : ingress FSM states
//   entry_t  : one stored buffer entry {sop, eop, data}
package eth_sw_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned RUNT_MIN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/eth_sw_ram.sv
// eth_sw_ram -- simple dual-port storage for the eth_sw packet buffer.
// Synchronous write; the read port is combinational so the addressed word
// reaches the egress registers in the same cycle.
// Ports:
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data (one entry)
//   raddr : read address
//   rdata : read data, combinational from raddr
module eth_sw_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned W     = 66,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    import eth_sw_pkg::*;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/eth_sw.sv
// eth_sw -- store-and-forward packet buffer. Only complete packets that fit
// in the buffer are forwarded, in arrival order and unmodified.
// Build option: define ETH_SW_RUNT_DROP_EN to discard packets shorter than
// RUNT_MIN words at their EOP.
// Ports:
//   clock   : sole clock, rising edge
//   reset   : synchronous active-high reset
//   DATAIN  : ingress data word
//   inSOP   : ingress first-word flag
//   inEOP   : ingress last-word flag
//   vld     : ingress word valid
//   DATAOUT : egress data word (registered, 0 when idle)
//   outSOP  : egress first-word flag (registered)
//   outEOP  : egress last-word flag (registered)
//   outvld  : egress word valid (registered)
module eth_sw #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] DATAIN,
    input  logic              inSOP,
    input  logic              inEOP,
    input  logic              vld,
    output logic [DATA_W-1:0] DATAOUT,
    output logic              outSOP,
    output logic              outEOP,
    output logic              outvld
);
    import eth_sw_pkg::*;

    localparam int unsigned    AW   = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]  FULL = AW'(DEPTH);
    localparam logic [AW-1:0]  ONE  = AW'(1);

    // wr_ptr is speculative; cm_ptr marks the end of the last committed
    // packet; egress reads only up to cm_ptr.
    logic [AW-1:0]     wr_ptr, cm_ptr, rd_ptr;
    logic [AW-1:0]     wr_nxt, cm_nxt;
    logic [AW-2:0]     waddr;
    logic              we;
    logic [DATA_W+1:0] wdata, rdata;
    logic              full_wr, full_cm;
    state_t            state, state_nxt;

`ifdef ETH_SW_RUNT_DROP_EN
    logic [3:0] cnt, cnt_nxt;
    logic       runt;
    // cnt holds words already stored, so the EOP word makes it cnt+1.
    assign runt = (cnt < 4'(RUNT_MIN - 1));
`endif

    assign full_wr = ((wr_ptr - rd_ptr) == FULL);
    assign full_cm = ((cm_ptr - rd_ptr) == FULL);
    assign wdata   = {inSOP, inEOP, DATAIN};

    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_ptr;
        cm_nxt    = cm_ptr;
        we        = 1'b0;
        waddr     = wr_ptr[AW-2:0];
`ifdef ETH_SW_RUNT_DROP_EN
        cnt_nxt   = cnt;
`endif
        if (vld) begin
            if (inSOP) begin
                // Any SOP restarts at the commit point, discarding a partial
                // packet. A SOP that finds the buffer full of committed data
                // is treated as an overflow of the new packet.
                waddr = cm_ptr[AW-2:0];
                if (full_cm) begin
                    wr_nxt    = cm_ptr;
                    state_nxt = inEOP ? IDLE : DROP;
                end else begin
                    we     = 1'b1;
                    wr_nxt = cm_ptr + ONE;
`ifdef ETH_SW_RUNT_DROP_EN
                    cnt_nxt = 4'd1;
`endif
                    if (inEOP) begin
                        state_nxt = IDLE;
`ifdef ETH_SW_RUNT_DROP_EN
                        wr_nxt = cm_ptr;
`else
                        cm_nxt = cm_ptr + ONE;
`endif
                    end else begin
                        state_nxt = RECV;
                    end
                end
            end else if (state == RECV) begin
                if (full_wr) begin
                    wr_nxt    = cm_ptr;
                    state_nxt = inEOP ? IDLE : DROP;
                end else begin
                    we     = 1'b1;
                    wr_nxt = wr_ptr + ONE;
`ifdef ETH_SW_RUNT_DROP_EN
                    cnt_nxt = (cnt == '1) ? cnt : cnt + 4'd1;
`endif
                    if (inEOP) begin
                        state_nxt = IDLE;
`ifdef ETH_SW_RUNT_DROP_EN
                        if (runt) begin
                            wr_nxt = cm_ptr;
                        end else begin
                            cm_nxt = wr_ptr + ONE;
                        end
`else
                        cm_nxt = wr_ptr + ONE;
`endif
                    end
                end
            end else if (state == DROP && inEOP) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            cm_ptr <= '0;
`ifdef ETH_SW_RUNT_DROP_EN
            cnt    <= '0;
`endif
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_nxt;
            cm_ptr <= cm_nxt;
`ifdef ETH_SW_RUNT_DROP_EN
            cnt    <= cnt_nxt;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            DATAOUT <= '0;
            outSOP  <= 1'b0;
            outEOP  <= 1'b0;
            outvld  <= 1'b0;
        end else if (rd_ptr != cm_ptr) begin
            rd_ptr  <= rd_ptr + ONE;
            DATAOUT <= rdata[DATA_W-1:0];
            outSOP  <= rdata[DATA_W+1];
            outEOP  <= rdata[DATA_W];
            outvld  <= 1'b1;
        end else begin
            DATAOUT <= '0;
            outSOP  <= 1'b0;
            outEOP  <= 1'b0;
            outvld  <= 1'b0;
        end
    end

    eth_sw_ram #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 2),
        .AW    (AW - 1)
    ) u_ram (
        .clk   (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_ptr[AW-2:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_eth_sw.sv
// tb_eth_sw -- directed self-checking bench for eth_sw (DEPTH=256, DATA_W=64).
module tb_eth_sw;
    import eth_sw_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] DATAIN;
    logic        inSOP, inEOP, vld;
    logic [63:0] DATAOUT;
    logic        outSOP, outEOP, outvld;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int eop_edge;

    entry_t exp_q[$];
    entry_t cap_q[$];
    int     cap_cyc[$];

    always #5 clock = ~clock;

    eth_sw #(
        .DEPTH  (256),
        .DATA_W (64)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .DATAIN  (DATAIN),
        .inSOP   (inSOP),
        .inEOP   (inEOP),
        .vld     (vld),
        .DATAOUT (DATAOUT),
        .outSOP  (outSOP),
        .outEOP  (outEOP),
        .outvld  (outvld)
    );

    // Capture every egress word with the number of the edge that produced it.
    always @(posedge clock) begin
        entry_t e;
        #1;
        cyc++;
        if (outvld) begin
            e.sop  = outSOP;
            e.eop  = outEOP;
            e.data = DATAOUT;
            cap_q.push_back(e);
            cap_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input entry_t w);
        @(negedge clock);
        vld    = 1'b1;
        inSOP  = w.sop;
        inEOP  = w.eop;
        DATAIN = w.data;
        eop_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            vld    = 1'b0;
            inSOP  = 1'b0;
            inEOP  = 1'b0;
            DATAIN = '0;
        end
    endtask

    task automatic send_pkt(input int n, input bit expect_it, input bit with_eop);
        entry_t w;
        for (int i = 0; i < n; i++) begin
            w.sop  = (i == 0);
            w.eop  = with_eop && (i == n - 1);
            w.data = {$urandom, $urandom};
            drive_word(w);
            if (expect_it) exp_q.push_back(w);
        end
    endtask

    task automatic start_test();
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    task automatic finish_test(input string tag, input int budget);
        int b = 0;
        int idx;
        int gaps = 0;
        while (cap_q.size() < exp_q.size() && b < budget) begin
            @(negedge clock);
            b++;
        end
        idle(8);
        check({tag, "_count"}, 128'(cap_q.size()), 128'(exp_q.size()));
        if (cap_q.size() > 0 && exp_q.size() > 0) begin
            idx = 0;
            for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
                if (cap_q[i] !== exp_q[i]) begin
                    idx = i;
                    break;
                end
            end
            check({tag, "_word"}, 128'(cap_q[idx]), 128'(exp_q[idx]));
        end
        for (int i = 1; i < cap_q.size(); i++) begin
            if (!cap_q[i-1].eop && cap_cyc[i] != cap_cyc[i-1] + 1) gaps++;
        end
        check({tag, "_contig"}, 128'(gaps), 128'(0));
    endtask

    initial begin
        entry_t w;
        int b;
        int e_edge;
        int n_before;

        reset = 1'b1; vld = 1'b0; inSOP = 1'b0; inEOP = 1'b0; DATAIN = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 128'({outSOP, outEOP, outvld, DATAOUT}), 128'(0));
        reset = 1'b0;
        idle(2);

        // 163-word packet, buffer empty: first word one edge after EOP edge.
        start_test();
        send_pkt(163, 1'b1, 1'b1);
        e_edge = eop_edge;
        idle(1);
        finish_test("p163", 400);
        check("p163_latency", 128'(cap_cyc.size() > 0 ? cap_cyc[0] : 0), 128'(e_edge + 1));

        // Stray word in IDLE without SOP is discarded; then a one-word packet.
        start_test();
        w.sop = 1'b0; w.eop = 1'b1; w.data = 64'h1234_5678_9ABC_DEF0;
        drive_word(w);
        idle(2);
        w.sop = 1'b1; w.eop = 1'b1; w.data = 64'hDEADBEEF_00000001;
        drive_word(w);
        e_edge = eop_edge;
`ifndef ETH_SW_RUNT_DROP_EN
        exp_q.push_back(w);
`endif
        idle(1);
        finish_test("p1w", 20);
`ifndef ETH_SW_RUNT_DROP_EN
        check("p1w_latency", 128'(cap_cyc.size() > 0 ? cap_cyc[0] : 0), 128'(e_edge + 1));
`endif

        // 300-word packet overflows the 256-word buffer; next packet intact.
        start_test();
        send_pkt(300, 1'b0, 1'b1);
        idle(2);
        send_pkt(10, 1'b1, 1'b1);
        idle(1);
        finish_test("ovf", 100);

        // Packet A abandoned by a new SOP after 5 words; only B emerges.
        start_test();
        send_pkt(5, 1'b0, 1'b0);
        send_pkt(9, 1'b1, 1'b1);
        idle(1);
        finish_test("restart", 60);

        // 4-word then 8-word packet.
        start_test();
`ifdef ETH_SW_RUNT_DROP_EN
        send_pkt(4, 1'b0, 1'b1);
`else
        send_pkt(4, 1'b1, 1'b1);
`endif
        send_pkt(8, 1'b1, 1'b1);
        idle(1);
        finish_test("p4p8", 60);

        // Reset in the middle of a 20-word egress.
        start_test();
        send_pkt(20, 1'b1, 1'b1);
        idle(1);
        b = 0;
        while (cap_q.size() < 5 && b < 40) begin
            @(negedge clock);
            b++;
        end
        check("rst_reached_egress", 128'(cap_q.size() >= 5), 128'(1));
        reset = 1'b1;
        @(negedge clock);
        check("rst_outputs", 128'({outSOP, outEOP, outvld, DATAOUT}), 128'(0));
        n_before = cap_q.size();
        check("rst_mid_egress", 128'(n_before < 20), 128'(1));
        check("rst_prefix", 128'(cap_q.size() > 0 ? cap_q[0] : '0), 128'(exp_q[0]));
        reset = 1'b0;
        idle(40);
        check("rst_residual", 128'(cap_q.size()), 128'(n_before));

        // Buffer usable again after reset.
        start_test();
        send_pkt(12, 1'b1, 1'b1);
        idle(1);
        finish_test("post_rst", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_sw.md
ETH_SW -- requirements
Module: eth_sw

Interface
REQ-001 Port clock, input, 1: sole clock; all logic on the rising edge.
REQ-002 Port reset, input, 1: synchronous, active-high reset.
REQ-003 Port DATAIN, input, 64: ingress data word.
REQ-004 Port inSOP, input, 1: ingress word is the first word of a packet.
REQ-005 Port inEOP, input, 1: ingress word is the last word of a packet.
REQ-006 Port vld, input, 1: ingress word valid; DATAIN, inSOP and inEOP are ignored when low.
REQ-007 Port DATAOUT, output, 64: egress data word, registered.
REQ-008 Port outSOP, output, 1: egress first-word flag, registered.
REQ-009 Port outEOP, output, 1: egress last-word flag, registered.
REQ-010 Port outvld, output, 1: egress word valid, registered.
REQ-011 Parameters: DEPTH, default 256, buffer words, power of two; DATA_W, default 64, word width.

Function
REQ-012 Block is a store-and-forward packet buffer: only complete, accepted packets are forwarded, in arrival order, with data unmodified.
REQ-013 Input FSM states:
- IDLE -> RECV on vld&inSOP.
- RECV -> IDLE on vld&inEOP.
- RECV -> DROP on overflow.
- DROP -> IDLE on vld&inEOP.
REQ-014 In IDLE, valid words without inSOP are discarded.
REQ-015 vld&inSOP&inEOP in IDLE is a complete one-word packet.
REQ-016 Each stored entry is 66 bits: data plus SOP and EOP tags.
REQ-017 Pointers are log2(DEPTH)+1 bits wide: write pointer (speculative), commit pointer and read pointer.
REQ-018 Words write at the write pointer; the commit pointer advances to the write pointer on the edge that stores the EOP word.
REQ-019 Overflow: a valid word arriving in RECV when the write pointer minus the read pointer equals DEPTH.
- The write pointer rewinds to the commit pointer; the FSM enters DROP.
- Remaining words of that packet are discarded.
REQ-020 SOP while in RECV: the partial packet is discarded (write pointer rewinds to commit), and the new packet starts in RECV with its SOP word stored.
REQ-021 SOP while in DROP: the FSM enters RECV and the new packet is stored.
REQ-022 Egress:
- While the read pointer is not equal to the commit pointer, one word per cycle is read into the output registers with outvld=1, and outSOP/outEOP come from the tags.
- Otherwise outvld, outSOP, outEOP and DATAOUT are 0.
REQ-023 There is no egress backpressure; consecutive packets are emitted back-to-back with no gap cycle.
REQ-024 Latency: EOP word sampled at edge k -> first word of that packet (outSOP=1) is visible after edge k+1 when the buffer was empty. Egress of stored packet N overlaps ingress of packet N+1.
REQ-025 Simultaneous ingress write and egress read in one cycle are both performed; occupancy counts use the read pointer at that edge.

Reset
REQ-026 reset=1 at a rising edge clears all pointers to 0, sets the FSM to IDLE and sets DATAOUT, outSOP, outEOP and outvld to 0.
REQ-027 Reset mid-packet or mid-egress discards all buffered and partial data; storage RAM contents need no clearing.

Configuration
REQ-028 With macro ETH_SW_RUNT_DROP_EN defined, a packet of fewer than 8 words is discarded at its EOP (write pointer rewinds; no commit); a per-packet 4-bit saturating word counter is compiled in.
REQ-029 Without ETH_SW_RUNT_DROP_EN, packets of every length of 1 word or more are forwarded and no counter exists.

Structure
REQ-030 Package eth_sw_pkg holds:
- DATA_W, DEPTH and runt minimum (8) constants.
- Input FSM state enum (IDLE, RECV, DROP).
- Packed struct of the 66-bit entry {sop, eop, data}.
REQ-031 Storage is one sub-module eth_sw_ram: simple dual-port RAM, DEPTH x 66, synchronous write, read data available to the egress register path in the same cycle it is addressed.

Verification
REQ-032 Packet of 163 words (SOP word, 161 middle, EOP word), random data -> 163 identical words out, outSOP on the first only, outEOP on the last only, outvld contiguous.
REQ-033 One-word packet 64'hDEADBEEF_00000001 (SOP&EOP) -> one egress cycle with outSOP=outEOP=outvld=1, DATAOUT equal to that word.
REQ-034 Packet of 300 words, DEPTH=256, no egress drain possible before overflow -> nothing emitted; a following 10-word packet is emitted intact.
REQ-035 Second SOP after 5 words of packet A, then a 9-word packet B -> only B is emitted.
REQ-036 Reset asserted mid-egress of a 20-word packet -> outputs are 0 from the next edge; no residual words appear after release.
REQ-037 4-word packet, then 8-word packet: ETH_SW_RUNT_DROP_EN defined -> only the 8-word packet is emitted; undefined -> both are emitted back-to-back.
